// File: rtl/pcs_pkg.sv
// Shared constants for the 1000BASE-X PCS transmit code-group sequencer.
// CFG states exist only when PCS_CONFIG_EN is defined.
package pcs_pkg;

   localparam int unsigned CG_W  = 8;
   localparam int unsigned CFG_W = 16;

   // Ordered-set selector values on tx_o_set
   localparam logic [CG_W-1:0] SET_I = 8'h01;
   localparam logic [CG_W-1:0] SET_S = 8'h05;
   localparam logic [CG_W-1:0] SET_D = 8'h0D;
   localparam logic [CG_W-1:0] SET_T = 8'h04;
   localparam logic [CG_W-1:0] SET_R = 8'h08;

   // Pre-8B/10B code-group octets
   localparam logic [CG_W-1:0] K28_5 = 8'hBC;
   localparam logic [CG_W-1:0] D16_2 = 8'h50;
   localparam logic [CG_W-1:0] K27_7 = 8'hFB;
   localparam logic [CG_W-1:0] K29_7 = 8'hFD;
   localparam logic [CG_W-1:0] K23_7 = 8'hF7;
   localparam logic [CG_W-1:0] K30_7 = 8'hFE;
   localparam logic [CG_W-1:0] D21_5 = 8'hB5;
   localparam logic [CG_W-1:0] D2_2  = 8'h42;

   typedef enum logic [3:0] {
      ST_IDLE_K,
      ST_IDLE_D,
      ST_SINGLE,
      ST_FILL_R
`ifdef PCS_CONFIG_EN
      ,
      ST_CFG1_A,
      ST_CFG1_B,
      ST_CFG1_C,
      ST_CFG1_D,
      ST_CFG2_A,
      ST_CFG2_B,
      ST_CFG2_C,
      ST_CFG2_D
`endif
   } state_e;

endpackage

// File: rtl/pcs_tx_code_group_seq.sv
// 1000BASE-X PCS transmit code-group sequencer: expands ordered-set requests into
// code-groups with K flag and parity. Optional /C1/ /C2/ generation via PCS_CONFIG_EN.
module pcs_tx_code_group_seq #(
   parameter logic [7:0] SET_I = pcs_pkg::SET_I,
   parameter logic [7:0] SET_S = pcs_pkg::SET_S,
   parameter logic [7:0] SET_D = pcs_pkg::SET_D,
   parameter logic [7:0] SET_T = pcs_pkg::SET_T,
   parameter logic [7:0] SET_R = pcs_pkg::SET_R
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic [pcs_pkg::CG_W-1:0]   tx_o_set,
   input  logic [pcs_pkg::CG_W-1:0]   TXD,
`ifdef PCS_CONFIG_EN
   input  logic                       xmit_config,
   input  logic [pcs_pkg::CFG_W-1:0]  config_reg,
`endif
   output logic                       TX_OSET_indicate,
   output logic [pcs_pkg::CG_W-1:0]   tx_code_group,
   output logic                       tx_is_k,
   output logic                       tx_even
);

   import pcs_pkg::*;

   state_e            r_state;
   logic [CG_W-1:0]   r_cg;
   logic              r_k;
   logic              r_even;
   logic              r_ind;

   state_e            w_nxt_state;
   logic [CG_W-1:0]   w_nxt_cg;
   logic              w_nxt_k;
   logic              w_nxt_ind;
   logic              w_nxt_is_even;

`ifdef PCS_CONFIG_EN
   logic [CFG_W-1:0]  r_cfg;
   logic [CFG_W-1:0]  w_nxt_cfg;
   logic              r_fill_cfg;
   logic              w_nxt_fill_cfg;
`endif

   assign w_nxt_is_even = ~r_even;

   // State and registered output stage
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= ST_IDLE_K;
         r_cg       <= K28_5;
         r_k        <= 1'b1;
         r_even     <= 1'b1;
         r_ind      <= 1'b0;
`ifdef PCS_CONFIG_EN
         r_cfg      <= '0;
         r_fill_cfg <= 1'b0;
`endif
      end else begin
         r_state    <= w_nxt_state;
         r_cg       <= w_nxt_cg;
         r_k        <= w_nxt_k;
         r_even     <= w_nxt_is_even;
         r_ind      <= w_nxt_ind;
`ifdef PCS_CONFIG_EN
         r_cfg      <= w_nxt_cfg;
         r_fill_cfg <= w_nxt_fill_cfg;
`endif
      end
   end

   // Next state, then the code-group that state emits
   always_comb begin
      w_nxt_state    = r_state;
      w_nxt_cg       = r_cg;
      w_nxt_k        = r_k;
      w_nxt_ind      = 1'b0;
`ifdef PCS_CONFIG_EN
      w_nxt_cfg      = r_cfg;
      w_nxt_fill_cfg = r_fill_cfg;
`endif

      if (r_ind) begin
`ifdef PCS_CONFIG_EN
         if (xmit_config) begin
            if (!w_nxt_is_even) begin
               w_nxt_state    = ST_FILL_R;
               w_nxt_fill_cfg = 1'b1;
            end else if (r_state == ST_CFG1_D) begin
               w_nxt_state    = ST_CFG2_A;
            end else begin
               w_nxt_state    = ST_CFG1_A;
            end
         end else begin
`endif
            // SINGLE code-group is chosen here; the decode below leaves it alone
            if (tx_o_set == SET_I) begin
               w_nxt_state = w_nxt_is_even ? ST_IDLE_K : ST_FILL_R;
`ifdef PCS_CONFIG_EN
               w_nxt_fill_cfg = 1'b0;
`endif
            end else begin
               w_nxt_state = ST_SINGLE;
               w_nxt_k     = 1'b1;
               if (tx_o_set == SET_S) begin
                  w_nxt_cg = K27_7;
               end else if (tx_o_set == SET_T) begin
                  w_nxt_cg = K29_7;
               end else if (tx_o_set == SET_R) begin
                  w_nxt_cg = K23_7;
               end else if (tx_o_set == SET_D) begin
                  w_nxt_cg = TXD;
                  w_nxt_k  = 1'b0;
               end else begin
                  w_nxt_cg = K30_7;
               end
            end
`ifdef PCS_CONFIG_EN
         end
`endif
      end else begin
         case (r_state)
            ST_IDLE_K: w_nxt_state = ST_IDLE_D;
`ifdef PCS_CONFIG_EN
            ST_FILL_R: w_nxt_state = r_fill_cfg ? ST_CFG1_A : ST_IDLE_K;
            ST_CFG1_A: w_nxt_state = ST_CFG1_B;
            ST_CFG1_B: w_nxt_state = ST_CFG1_C;
            ST_CFG1_C: w_nxt_state = ST_CFG1_D;
            ST_CFG2_A: w_nxt_state = ST_CFG2_B;
            ST_CFG2_B: w_nxt_state = ST_CFG2_C;
            ST_CFG2_C: w_nxt_state = ST_CFG2_D;
`else
            ST_FILL_R: w_nxt_state = ST_IDLE_K;
`endif
            default:   w_nxt_state = ST_IDLE_K;
         endcase
      end

      case (w_nxt_state)
         ST_IDLE_K: begin
            w_nxt_cg  = K28_5;
            w_nxt_k   = 1'b1;
         end
         ST_IDLE_D: begin
            w_nxt_cg  = D16_2;
            w_nxt_k   = 1'b0;
            w_nxt_ind = 1'b1;
         end
         ST_SINGLE: begin
            w_nxt_ind = 1'b1;
         end
         ST_FILL_R: begin
            w_nxt_cg  = K23_7;
            w_nxt_k   = 1'b1;
         end
`ifdef PCS_CONFIG_EN
         ST_CFG1_A, ST_CFG2_A: begin
            w_nxt_cg  = K28_5;
            w_nxt_k   = 1'b1;
            w_nxt_cfg = config_reg;
         end
         ST_CFG1_B: begin
            w_nxt_cg  = D21_5;
            w_nxt_k   = 1'b0;
         end
         ST_CFG2_B: begin
            w_nxt_cg  = D2_2;
            w_nxt_k   = 1'b0;
         end
         ST_CFG1_C, ST_CFG2_C: begin
            w_nxt_cg  = r_cfg[7:0];
            w_nxt_k   = 1'b0;
         end
         ST_CFG1_D, ST_CFG2_D: begin
            w_nxt_cg  = r_cfg[15:8];
            w_nxt_k   = 1'b0;
            w_nxt_ind = 1'b1;
         end
`endif
         default: begin
            w_nxt_cg  = K28_5;
            w_nxt_k   = 1'b1;
         end
      endcase
   end

   assign TX_OSET_indicate = r_ind;
   assign tx_code_group    = r_cg;
   assign tx_is_k          = r_k;
   assign tx_even          = r_even;

endmodule

// File: tb/tb_pcs_tx_code_group_seq.sv
// Directed bench for pcs_tx_code_group_seq; config checks built only with PCS_CONFIG_EN.
module tb_pcs_tx_code_group_seq;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [7:0]  tx_o_set;
   logic [7:0]  TXD;
`ifdef PCS_CONFIG_EN
   logic        xmit_config;
   logic [15:0] config_reg;
`endif
   logic        TX_OSET_indicate;
   logic [7:0]  tx_code_group;
   logic        tx_is_k;
   logic        tx_even;

   int passes = 0;
   int total  = 0;

   pcs_tx_code_group_seq dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .tx_o_set         (tx_o_set),
      .TXD              (TXD),
`ifdef PCS_CONFIG_EN
      .xmit_config      (xmit_config),
      .config_reg       (config_reg),
`endif
      .TX_OSET_indicate (TX_OSET_indicate),
      .tx_code_group    (tx_code_group),
      .tx_is_k          (tx_is_k),
      .tx_even          (tx_even)
   );

   always #5 CLK = ~CLK;

   // Advance one edge, then compare {code-group, K, even, indicate}
   task automatic step_chk(input string tag, input logic [7:0] cg, input logic k,
                           input logic ev, input logic ind);
      logic [10:0] obs;
      logic [10:0] exp;
      @(posedge CLK);
      #1;
      obs = {tx_code_group, tx_is_k, tx_even, TX_OSET_indicate};
      exp = {cg, k, ev, ind};
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed cg=%h k=%b even=%b ind=%b expected cg=%h k=%b even=%b ind=%b",
                  tag, obs[10:3], obs[2], obs[1], obs[0], exp[10:3], exp[2], exp[1], exp[0]);
   endtask

   initial begin
      RESET    = 1'b1;
      tx_o_set = 8'h01;
      TXD      = 8'h00;
`ifdef PCS_CONFIG_EN
      xmit_config = 1'b0;
      config_reg  = 16'h0000;
`endif
      step_chk("rst0", 8'hBC, 1'b1, 1'b1, 1'b0);
      step_chk("rst1", 8'hBC, 1'b1, 1'b1, 1'b0);
      step_chk("rst2", 8'hBC, 1'b1, 1'b1, 1'b0);
      RESET = 1'b0;
      step_chk("post_rst_d", 8'h50, 1'b0, 1'b0, 1'b1);
      step_chk("idle_k",     8'hBC, 1'b1, 1'b1, 1'b0);
      step_chk("idle_d",     8'h50, 1'b0, 1'b0, 1'b1);

      // Frame: S D D T R then /I/ lands odd-aligned and needs FILL_R
      tx_o_set = 8'h05;
      step_chk("frm_s", 8'hFB, 1'b1, 1'b1, 1'b1);
      tx_o_set = 8'h0D; TXD = 8'hA5;
      step_chk("frm_d0", 8'hA5, 1'b0, 1'b0, 1'b1);
      TXD = 8'h3C;
      step_chk("frm_d1", 8'h3C, 1'b0, 1'b1, 1'b1);
      tx_o_set = 8'h04; TXD = 8'hFF;
      step_chk("frm_t", 8'hFD, 1'b1, 1'b0, 1'b1);
      tx_o_set = 8'h08;
      step_chk("frm_r", 8'hF7, 1'b1, 1'b1, 1'b1);
      tx_o_set = 8'h01;
      step_chk("fill_r", 8'hF7, 1'b1, 1'b0, 1'b0);
      tx_o_set = 8'h05;
      step_chk("fill_idle_k", 8'hBC, 1'b1, 1'b1, 1'b0);
      tx_o_set = 8'h01;
      step_chk("fill_idle_d", 8'h50, 1'b0, 1'b0, 1'b1);

      // Invalid selector gives one /V/
      tx_o_set = 8'h77;
      step_chk("inv_v", 8'hFE, 1'b1, 1'b1, 1'b1);
      tx_o_set = 8'h01;
      step_chk("inv_fill", 8'hF7, 1'b1, 1'b0, 1'b0);
      step_chk("inv_idle_k", 8'hBC, 1'b1, 1'b1, 1'b0);
      step_chk("inv_idle_d", 8'h50, 1'b0, 1'b0, 1'b1);

      // Reset while /D/ is on the output
      tx_o_set = 8'h05;
      step_chk("mr_s", 8'hFB, 1'b1, 1'b1, 1'b1);
      tx_o_set = 8'h0D; TXD = 8'h5A;
      step_chk("mr_d", 8'h5A, 1'b0, 1'b0, 1'b1);
      RESET = 1'b1;
      step_chk("mr_rst", 8'hBC, 1'b1, 1'b1, 1'b0);
      RESET = 1'b0; tx_o_set = 8'h01;
      step_chk("mr_idle_d", 8'h50, 1'b0, 1'b0, 1'b1);

`ifdef PCS_CONFIG_EN
      xmit_config = 1'b1;
      config_reg  = 16'h01A0;
      step_chk("c1_k",  8'hBC, 1'b1, 1'b1, 1'b0);
      step_chk("c1_d",  8'hB5, 1'b0, 1'b0, 1'b0);
      step_chk("c1_lo", 8'hA0, 1'b0, 1'b1, 1'b0);
      step_chk("c1_hi", 8'h01, 1'b0, 1'b0, 1'b1);
      step_chk("c2_k",  8'hBC, 1'b1, 1'b1, 1'b0);
      step_chk("c2_d",  8'h42, 1'b0, 1'b0, 1'b0);
      step_chk("c2_lo", 8'hA0, 1'b0, 1'b1, 1'b0);
      step_chk("c2_hi", 8'h01, 1'b0, 1'b0, 1'b1);
      step_chk("c1b_k", 8'hBC, 1'b1, 1'b1, 1'b0);
      step_chk("c1b_d", 8'hB5, 1'b0, 1'b0, 1'b0);
      step_chk("c1b_lo", 8'hA0, 1'b0, 1'b1, 1'b0);
      step_chk("c1b_hi", 8'h01, 1'b0, 1'b0, 1'b1);
      xmit_config = 1'b0;
      step_chk("cx_idle_k", 8'hBC, 1'b1, 1'b1, 1'b0);
      step_chk("cx_idle_d", 8'h50, 1'b0, 1'b0, 1'b1);
      // Odd-aligned config entry goes through FILL_R
      tx_o_set = 8'h05;
      step_chk("co_s", 8'hFB, 1'b1, 1'b1, 1'b1);
      xmit_config = 1'b1;
      config_reg  = 16'h2233;
      step_chk("co_fill", 8'hF7, 1'b1, 1'b0, 1'b0);
      step_chk("co_c1_k", 8'hBC, 1'b1, 1'b1, 1'b0);
      step_chk("co_c1_d", 8'hB5, 1'b0, 1'b0, 1'b0);
      step_chk("co_c1_lo", 8'h33, 1'b0, 1'b1, 1'b0);
      step_chk("co_c1_hi", 8'h22, 1'b0, 1'b0, 1'b1);
`endif

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
